// File: rtl/mem_loader.sv
// mem_loader: streams LOAD_LEN bytes from an upstream byte source into a
// 16-entry memory starting at START_ADR, then reports done.
// Optional readback verification is built when LOADER_VERIFY_EN is defined;
// it re-reads the loaded range and flags a checksum mismatch on error.
module mem_loader #(
    parameter int unsigned LOAD_LEN  = 16,
    parameter logic [3:0]  START_ADR = 4'd0
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       clken,
    input  logic       start,
    input  logic       byte_valid,
    input  logic [7:0] byte_in,
    output logic       byte_ready,
    output logic [3:0] mem_adr,
    output logic [7:0] mem_data,
    output logic       mem_write,
    input  logic [7:0] mem_value,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [4:0] LEN5 = 5'(LOAD_LEN);

`ifdef LOADER_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_VERIFY, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
`endif

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_adr;
    logic [4:0] r_count;
    logic [7:0] r_checksum;
    logic [7:0] r_data;
    logic       w_start;
    logic       w_xfer;
    logic       w_wr_done;
    logic       w_last;

    assign w_start   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
    assign w_xfer    = (r_state == S_LOAD) && clken && byte_valid;
    assign w_wr_done = (r_state == S_WRITE) && clken;
    assign w_last    = (r_count + 5'd1) == LEN5;

    assign mem_adr  = r_adr;
    assign mem_data = r_data;

`ifdef LOADER_VERIFY_EN
    logic [4:0] r_vcnt;
    logic [7:0] r_rsum;
    logic       r_error;
    logic [7:0] w_rsum_nxt;

    // Running readback sum including the value arriving this cycle.
    assign w_rsum_nxt = r_rsum + mem_value;
    assign error      = r_error;
`else
    logic w_unused;

    // Readback data and checksum have no consumer without verification.
    assign w_unused = ^{mem_value, r_checksum};
    assign error    = 1'b0;
`endif

    // State register.
    always_ff @(posedge sysclk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        mem_write  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LOAD;
            end
            S_LOAD: begin
                byte_ready = clken;
                busy       = 1'b1;
                if (w_xfer) w_next = S_WRITE;
            end
            S_WRITE: begin
                mem_write = 1'b1;
                busy      = 1'b1;
                if (clken) begin
`ifdef LOADER_VERIFY_EN
                    w_next = w_last ? S_VERIFY : S_LOAD;
`else
                    w_next = w_last ? S_DONE : S_LOAD;
`endif
                end
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY: begin
                busy = 1'b1;
                if (r_vcnt == LEN5) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                done = 1'b1;
                if (start) w_next = S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Address, count, data and checksum datapath.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_adr      <= START_ADR;
            r_count    <= 5'd0;
            r_checksum <= 8'd0;
            r_data     <= 8'd0;
`ifdef LOADER_VERIFY_EN
            r_vcnt     <= 5'd0;
            r_rsum     <= 8'd0;
            r_error    <= 1'b0;
`endif
        end else begin
            if (w_start) begin
                r_adr      <= START_ADR;
                r_count    <= 5'd0;
                r_checksum <= 8'd0;
`ifdef LOADER_VERIFY_EN
                r_error    <= 1'b0;
`endif
            end
            if (w_xfer) begin
                r_data     <= byte_in;
                r_checksum <= r_checksum + byte_in;
            end
            if (w_wr_done) begin
                r_count <= r_count + 5'd1;
`ifdef LOADER_VERIFY_EN
                // The readback walk starts over from the first loaded address.
                if (w_last) begin
                    r_adr  <= START_ADR;
                    r_vcnt <= 5'd0;
                    r_rsum <= 8'd0;
                end else begin
                    r_adr <= r_adr + 4'd1;
                end
`else
                r_adr <= r_adr + 4'd1;
`endif
            end
`ifdef LOADER_VERIFY_EN
            // Issue one address per cycle; sum the data that returns a cycle later.
            if (r_state == S_VERIFY) begin
                if (r_vcnt != LEN5) begin
                    r_adr  <= r_adr + 4'd1;
                    r_vcnt <= r_vcnt + 5'd1;
                end
                if (r_vcnt != 5'd0) r_rsum <= w_rsum_nxt;
                if ((r_vcnt == LEN5) && (w_rsum_nxt != r_checksum)) r_error <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter LOAD_LEN, default 16: number of bytes written per load; legal range 1..16.
REQ-002 Parameter START_ADR, default 0: first memory address written; 4 bits.
REQ-003 sysclk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of sysclk.
REQ-005 clken  input  1  clock enable shared with the memory; memory writes complete only on clken-qualified edges.
REQ-006 start  input  1  single-cycle request to begin a load.
REQ-007 byte_valid  input  1  upstream byte present on byte_in.
REQ-008 byte_in  input  8  program byte from the upstream source.
REQ-009 byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 mem_adr  output  4  address to the memory.
REQ-011 mem_data  output  8  write data to the memory.
REQ-012 mem_write  output  1  write strobe to the memory.
REQ-013 mem_value  input  8  memory read data, registered by the memory one sysclk after mem_adr.
REQ-014 busy  output  1  load or verify in progress.
REQ-015 done  output  1  load sequence finished.
REQ-016 error  output  1  readback checksum mismatch; present only with LOADER_VERIFY_EN, otherwise tied 0.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, WRITE, VERIFY (macro only) and DONE.
REQ-018 IDLE: byte_ready=0, busy=0; start=1 -> LOAD, with adr=START_ADR, count=0, checksum=0, done=0, error=0.
REQ-019 LOAD: byte_ready = clken; a transfer occurs on an edge where byte_valid & byte_ready; then mem_data<=byte_in, checksum<=checksum+byte_in (mod 256), -> WRITE.
REQ-020 WRITE: mem_write=1, byte_ready=0, mem_adr/mem_data held stable until the next clken-qualified edge, which completes the write.
REQ-021 On write completion, adr SHALL increment modulo 16 (15 wraps to 0) and count SHALL increment; if count reaches LOAD_LEN -> VERIFY (macro) or DONE, else -> LOAD.
REQ-022 While clken=0 no transfer or write completion SHALL occur; state and outputs hold.
REQ-023 byte_valid without byte_ready SHALL be ignored, and the byte SHALL NOT be consumed.
REQ-024 start SHALL be ignored in LOAD, WRITE and VERIFY; in DONE, start=1 SHALL restart exactly as from IDLE.
REQ-025 busy=1 in LOAD, WRITE and VERIFY; done=1 only in DONE, and held until restart or reset.
REQ-026 mem_adr SHALL equal the current adr in all states; mem_write SHALL be 1 only in WRITE.
REQ-027 Worst-case throughput SHALL be one byte per two clken-qualified edges.

Reset
REQ-028 Synchronous reset SHALL force IDLE from any state, including mid-WRITE, with mem_write=0 on the first post-reset cycle.
REQ-029 Reset values SHALL be: byte_ready=0, mem_adr=START_ADR, mem_data=0, mem_write=0, busy=0, done=0, error=0, count=0, checksum=0.

Configuration
REQ-030 The macro LOADER_VERIFY_EN SHALL control readback verification.
REQ-031 With LOADER_VERIFY_EN defined: VERIFY re-walks LOAD_LEN addresses from START_ADR, ignoring clken, one address per sysclk.
REQ-032 In VERIFY, each mem_value SHALL be summed one cycle after its address is driven; after the last sum -> DONE.
REQ-033 In VERIFY, error SHALL be set if the readback sum differs from checksum; error is sticky until restart or reset.
REQ-034 Without LOADER_VERIFY_EN: the VERIFY state and readback logic SHALL be absent, LOAD_LEN-th write goes directly to DONE, and error is constant 0.

Verification
REQ-035 Defaults, clken=1, byte_valid always 1, bytes 0x09,0x1A,0x2B,0xE0,0xF0,0x00 x11 -> mem[0..15] hold those values, done=1 after 32 byte cycles, busy then 0.
REQ-036 START_ADR=14, LOAD_LEN=4, bytes 0xA1..0xA4 -> writes to addresses 14,15,0,1 (wrap); done=1.
REQ-037 clken toggling 1-of-3 cycles, byte_valid gapped -> no lost or duplicated bytes, mem_write held stable across clken=0, final contents match.
REQ-038 reset asserted in WRITE for byte 5 -> next cycle IDLE, mem_write=0, busy=0; new start reloads from START_ADR.
REQ-039 LOADER_VERIFY_EN, bench memory model corrupts address 3 (0xE0 -> 0xE1) -> error=1 in DONE; with the model uncorrupted -> error=0.
REQ-040 start pulsed mid-LOAD -> ignored; start in DONE -> done=0, error=0, busy=1 next cycle.
